// File: rtl/four_12_12_st2_error_buffer_if.sv
// four_12_12_st2_error_buffer_if: tap-error stream from the error buffer to the tap-update datapath
interface four_12_12_st2_error_buffer_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] tap_error;
  logic tap_error_vld;
  logic tap_error_fst;
  logic tap_error_lst;
  logic tap_error_rdy;
  modport master (output tap_error, tap_error_vld, tap_error_fst, tap_error_lst, input tap_error_rdy);
  modport slave (input tap_error, tap_error_vld, tap_error_fst, tap_error_lst, output tap_error_rdy);
endinterface

// File: rtl/four_12_12_st2_error_buffer.sv
// four_12_12_st2_error_buffer: phase-indexed stage-2 error store streaming one phase per update; ST2_ERROR_BUF_STATUS_EN adds the written-bitmap check
module four_12_12_st2_error_buffer #(
  parameter int DATA_W = 32,
  parameter int TAPS = 12,
  parameter int PHASES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic error_valid,
  input  logic [DATA_W-1:0] error_value,
  input  logic [3:0] error_phase,
  input  logic [31:0] error_sub_address,
  input  logic [3:0] error_phase_read,
  input  logic error_update_first,
  four_12_12_st2_error_buffer_if.master tap,
  output logic buffer_busy,
  output logic overrun_err,
  output logic range_err,
  output logic incomplete_err
);
  localparam int N = PHASES * TAPS;
  localparam logic [3:0] NPH = 4'(PHASES);
  localparam logic [3:0] NTAP = 4'(TAPS);
  localparam logic [3:0] LAST = 4'(TAPS - 1);
  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [N];
  logic [3:0] rd_phase, rd_cnt, wr_tap;
  logic [6:0] wr_idx, rd_idx;
  logic wr_ok, wr_bad, start, start_ok, load, unused_sub;
  assign wr_tap = error_sub_address[3:0];
  assign unused_sub = ^error_sub_address[31:4];
  assign wr_ok = error_valid & (error_phase < NPH) & (wr_tap < NTAP);
  assign wr_bad = error_valid & ~wr_ok;
  assign wr_idx = 7'(error_phase) * 7'(TAPS) + 7'(wr_tap);
  assign rd_idx = 7'(rd_phase) * 7'(TAPS) + 7'(rd_cnt);
  assign buffer_busy = (state == READ) | tap.tap_error_vld;
  assign start = error_update_first & ~buffer_busy;
  assign start_ok = start & (error_phase_read < NPH);
  assign load = (state == READ) & (~tap.tap_error_vld | tap.tap_error_rdy);
  // next state: accept a valid start in IDLE, return after loading the last tap
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? (start_ok ? READ : IDLE) : ((load && rd_cnt == LAST) ? IDLE : READ);
  end
  // state register plus latched read phase and tap counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rd_phase <= '0;
      rd_cnt <= '0;
    end else begin
      state <= state_d;
      if (start_ok) begin
        rd_phase <= error_phase_read;
        rd_cnt <= '0;
      end else if (load) rd_cnt <= rd_cnt + 4'd1;
    end
  end
  // store write; unreset so a same-cycle load sees the old word
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= error_value;
  end
  // output register: load when empty or draining, otherwise hold until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      tap.tap_error <= '0;
      tap.tap_error_vld <= 1'b0;
      tap.tap_error_fst <= 1'b0;
      tap.tap_error_lst <= 1'b0;
    end else if (load) begin
      tap.tap_error <= mem[rd_idx];
      tap.tap_error_vld <= 1'b1;
      tap.tap_error_fst <= rd_cnt == 4'd0;
      tap.tap_error_lst <= rd_cnt == LAST;
    end else if (tap.tap_error_rdy) tap.tap_error_vld <= 1'b0;
  end
  // sticky overrun and range flags
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_err <= 1'b0;
      range_err <= 1'b0;
    end else begin
      if (error_update_first & buffer_busy) overrun_err <= 1'b1;
      if (wr_bad | (start & ~start_ok)) range_err <= 1'b1;
    end
  end
`ifdef ST2_ERROR_BUF_STATUS_EN
  logic [N-1:0] written;
  logic [6:0] chk_base, clr_base;
  assign chk_base = 7'(error_phase_read) * 7'(TAPS);
  assign clr_base = 7'(rd_phase) * 7'(TAPS);
  // written-bitmap: rows checked at start, cleared on last handshake, a write in the same cycle wins
  always_ff @(posedge clk) begin
    if (reset) begin
      written <= '0;
      incomplete_err <= 1'b0;
    end else begin
      if (start_ok && written[chk_base +: TAPS] != {TAPS{1'b1}}) incomplete_err <= 1'b1;
      if (tap.tap_error_vld & tap.tap_error_rdy & tap.tap_error_lst) written[clr_base +: TAPS] <= '0;
      if (wr_ok) written[wr_idx] <= 1'b1;
    end
  end
`else
  assign incomplete_err = 1'b0;
`endif
endmodule

// File: doc/four_12_12_st2_error_buffer.md
# four_12_12_st2_error_buffer

Stage-2 error buffer sitting directly downstream of the stage-2 error FIFO controller. It captures each accepted error word into a phase-indexed store of 10 phases × 12 taps. When the controller signals a tap update, it streams the selected phase's 12 errors, in tap order, to the tap-update datapath over a valid/ready handshake.

## Interface
- DATA_W, 32, error word width (float_24_8 packed)
- TAPS, 12, errors per phase
- PHASES, 10, phase slots in the store

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- error_valid  in  1  error word accepted upstream this cycle (write strobe)
- error_value  in  DATA_W  error word
- error_phase  in  4  write phase slot
- error_sub_address  in  32  write tap index; only bits [3:0] are decoded
- error_phase_read  in  4  phase slot to stream on the next update
- error_update_first  in  1  single-cycle pulse that starts a read-out
- tap_error_rdy  in  1  downstream ready
- tap_error  out  DATA_W  streamed error word
- tap_error_vld  out  1  tap_error valid
- tap_error_fst  out  1  first word of a phase burst (tap 0)
- tap_error_lst  out  1  last word of a phase burst (tap TAPS-1)
- buffer_busy  out  1  read-out in progress
- overrun_err  out  1  sticky: start pulse arrived while busy
- range_err  out  1  sticky: write or read phase/tap out of range
- incomplete_err  out  1  sticky, compiled by macro: phase read before all taps written

## Operation
- Store: PHASES×TAPS register array, index = phase*TAPS + tap. The array is not reset.
- Write:
  - Occurs when error_valid=1, error_phase<PHASES and error_sub_address[3:0]<TAPS.
  - An out-of-range write is dropped and sets range_err.
  - Writes are accepted in every state.
- FSM states IDLE, READ.
- IDLE:
  - On error_update_first=1, latch rd_phase=error_phase_read, clear rd_cnt, go to READ.
  - If error_phase_read≥PHASES, stay IDLE and set range_err.
- READ:
  - Load condition: (~tap_error_vld | tap_error_rdy).
  - On a load cycle, the output register takes mem[rd_phase*TAPS+rd_cnt]; set tap_error_vld=1, tap_error_fst=(rd_cnt==0), tap_error_lst=(rd_cnt==TAPS-1).
  - After each load, rd_cnt increments.
  - After the load with rd_cnt==TAPS-1, go to IDLE.
- Output register:
  - tap_error_vld clears on tap_error_rdy when no new load occurs.
  - Data, fst and lst are held stable while vld=1 and rdy=0.
- buffer_busy = (state==READ) | tap_error_vld.
- error_update_first while buffer_busy=1: the pulse is ignored and overrun_err is set.
- Same-cycle write and read of one entry: the read returns the old contents.
- Sticky flags clear only on reset.

## Timing
- Reset values:
  - All outputs 0: tap_error=0, vld/fst/lst=0, buffer_busy=0, all error flags 0.
  - state=IDLE, rd_cnt=0.
- Write latency: a word written at edge k is readable by a load at edge k+1 or later.
- Start latency: error_update_first sampled high at edge N gives the first load at edge N+1, so tap_error_vld is high after N+1.
- Throughput: with tap_error_rdy held at 1, a burst is TAPS consecutive vld cycles and buffer_busy falls one cycle after the last handshake.
- A back-to-back start is accepted only once buffer_busy is 0.
- Reset mid-burst: the burst aborts at the next edge and the outputs return to reset values. Store contents are undefined to the user.

## Configuration
- ST2_ERROR_BUF_STATUS_EN defined:
  - Adds a PHASES×TAPS written-bitmap. A bit is set on a valid write.
  - At read start, the whole row for rd_phase is checked. If the row is not all ones, incomplete_err is set.
  - The row is cleared when its burst's last word handshakes.
  - The stream is produced regardless of the check.
- Macro not defined: no bitmap is built and incomplete_err is tied to 0.

## Test plan
- Write values 0x100+p*12+t for all p<10, t<12; start with error_phase_read=3, rdy=1 -> 12 consecutive words 0x124..0x12F, fst on 0x124, lst on 0x12F, first vld one cycle after the start edge.
- Same setup with phase 9 and rdy toggling 1,0,1,0 -> words 0x16C..0x177 with none lost or duplicated; data held during rdy=0.
- Second error_update_first pulse 4 cycles into a burst -> burst completes unchanged, overrun_err=1.
- Write with error_sub_address=12 or error_phase=10 -> no store change, range_err=1. Start with error_phase_read=10 -> no burst, range_err=1.
- Assert reset at word 5 of a burst -> next cycle vld=0, busy=0, all flags 0. A new start then streams correctly.
- With ST2_ERROR_BUF_STATUS_EN: write taps 0..10 of phase 2 only, then read phase 2 -> incomplete_err=1. Write all 12 taps of phase 4, then read it -> flag unchanged.
